// File: rtl/wb_regfile.sv
// Write-back select + 32-entry register file with two combinational read ports and a retired-write counter.
// Optional `WB_BYPASS_EN: same-cycle write-through to the read ports; otherwise reads show the pre-write array.
module wb_regfile #(
   parameter int N     = 32,
   parameter int NREG  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       WB_in,
   input  logic [4:0]       loadreg,
   input  logic [N-1:0]     readdata,
   input  logic [N-1:0]     Aluresult,
   input  logic [4:0]       rs1_addr,
   input  logic [4:0]       rs2_addr,
   output logic [N-1:0]     rs1_data,
   output logic [N-1:0]     rs2_data,
   output logic [N-1:0]     wb_data,
   output logic             wb_en,
   output logic [4:0]       wb_rd,
   output logic [CNT_W-1:0] wb_count
);

   logic [N-1:0]     r_regs [NREG];
   logic [CNT_W-1:0] r_count;

   logic [N-1:0]     w_wb_data;
   logic             w_wb_en;
   logic             w_dst_ok;
   logic [N-1:0]     w_rd1;
   logic [N-1:0]     w_rd2;

   assign w_wb_data = WB_in[0] ? readdata : Aluresult;
   assign w_wb_en   = WB_in[1] && (loadreg != 5'd0);
   // Indices beyond NREG (only possible when NREG < 32) are silently dropped.
   assign w_dst_ok  = int'(loadreg) < NREG;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
         r_count <= '0;
      end else if (w_wb_en && w_dst_ok) begin
         r_regs[loadreg] <= w_wb_data;
         r_count         <= r_count + CNT_W'(1);
      end
   end

   // x0 and out-of-range addresses read as zero regardless of array contents.
   always_comb begin
      w_rd1 = '0;
      w_rd2 = '0;
      if (rs1_addr != 5'd0 && int'(rs1_addr) < NREG) begin
         w_rd1 = r_regs[rs1_addr];
      end
      if (rs2_addr != 5'd0 && int'(rs2_addr) < NREG) begin
         w_rd2 = r_regs[rs2_addr];
      end
   end

`ifdef WB_BYPASS_EN
   always_comb begin
      rs1_data = w_rd1;
      rs2_data = w_rd2;
      if (w_wb_en && !rst && rs1_addr == loadreg) begin
         rs1_data = w_wb_data;
      end
      if (w_wb_en && !rst && rs2_addr == loadreg) begin
         rs2_data = w_wb_data;
      end
   end
`else
   assign rs1_data = w_rd1;
   assign rs2_data = w_rd2;
`endif

   assign wb_data  = w_wb_data;
   assign wb_en    = w_wb_en;
   assign wb_rd    = loadreg;
   assign wb_count = r_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, mux, commit, x0 guard, same-cycle read, reset priority, counter wrap.
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  WB_in;
   logic [4:0]  loadreg;
   logic [31:0] readdata;
   logic [31:0] Aluresult;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data, rs2_data, wb_data;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_count;

   logic [31:0] s_rs1_data, s_rs2_data, s_wb_data;
   logic        s_wb_en;
   logic [4:0]  s_wb_rd;
   logic [3:0]  s_wb_count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   wb_regfile u_dut (
      .clk(clk), .rst(rst), .WB_in(WB_in), .loadreg(loadreg),
      .readdata(readdata), .Aluresult(Aluresult),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .wb_data(wb_data), .wb_en(wb_en), .wb_rd(wb_rd), .wb_count(wb_count)
   );

   wb_regfile #(.CNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .WB_in(WB_in), .loadreg(loadreg),
      .readdata(readdata), .Aluresult(Aluresult),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(s_rs1_data), .rs2_data(s_rs2_data),
      .wb_data(s_wb_data), .wb_en(s_wb_en), .wb_rd(s_wb_rd), .wb_count(s_wb_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] wb, input logic [4:0] rd,
                        input logic [31:0] mem, input logic [31:0] alu);
      WB_in     = wb;
      loadreg   = rd;
      readdata  = mem;
      Aluresult = alu;
      #1;
   endtask

   task automatic bubble();
      drive(2'b00, 5'd0, 32'h0, 32'h0);
   endtask

   initial begin
      rst = 1'b1;
      rs1_addr = 5'd0;
      rs2_addr = 5'd0;
      bubble();
      step();
      rst = 1'b0;
      step();

      // Reset state across every address on both ports
      for (int a = 0; a < 32; a++) begin
         rs1_addr = 5'(a);
         rs2_addr = 5'(31 - a);
         #1;
         chk("reset_rs1", rs1_data, 32'h0);
         chk("reset_rs2", rs2_data, 32'h0);
      end
      chk("reset_cnt", wb_count, 32'd0);

      // 1. preload x5, then reset clears it
      drive(2'b10, 5'd5, 32'h0, 32'h0000DEAD);
      step();
      bubble();
      rs1_addr = 5'd5;
      #1;
      chk("preload_x5", rs1_data, 32'h0000DEAD);
      chk("preload_cnt", wb_count, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("rst_x5", rs1_data, 32'h0);
      chk("rst_cnt", wb_count, 32'd0);

      // 2. ALU write-back
      drive(2'b10, 5'd3, 32'h0000FFFF, 32'h00001234);
      chk("alu_wbdata", wb_data, 32'h00001234);
      chk("alu_wben", 32'(wb_en), 32'd1);
      chk("alu_wbrd", 32'(wb_rd), 32'd3);
      step();
      bubble();
      rs1_addr = 5'd3;
      #1;
      chk("alu_x3", rs1_data, 32'h00001234);
      chk("alu_cnt", wb_count, 32'd1);

      // 3. Load write-back
      drive(2'b11, 5'd7, 32'hCAFEF00D, 32'h00001111);
      chk("ld_wbdata", wb_data, 32'hCAFEF00D);
      step();
      bubble();
      rs2_addr = 5'd7;
      #1;
      chk("ld_x7", rs2_data, 32'hCAFEF00D);
      chk("ld_cnt", wb_count, 32'd2);

      // 4. x0 guard
      drive(2'b10, 5'd0, 32'h0, 32'h00000055);
      chk("x0_wben", 32'(wb_en), 32'd0);
      step();
      bubble();
      rs1_addr = 5'd0;
      #1;
      chk("x0_read", rs1_data, 32'h0);
      chk("x0_cnt", wb_count, 32'd2);

      // RegWrite=0: mux still selects, nothing commits
      drive(2'b01, 5'd3, 32'hA5A5A5A5, 32'h0BADBEEF);
      chk("norw_wbdata", wb_data, 32'hA5A5A5A5);
      chk("norw_wben", 32'(wb_en), 32'd0);
      step();
      bubble();
      rs1_addr = 5'd3;
      #1;
      chk("norw_x3", rs1_data, 32'h00001234);
      chk("norw_cnt", wb_count, 32'd2);

      // 5. Same-cycle read of the register being written
      drive(2'b10, 5'd9, 32'h0, 32'h00000001);
      step();
      rs1_addr = 5'd9;
      rs2_addr = 5'd9;
      drive(2'b10, 5'd9, 32'h0, 32'h00000002);
`ifdef WB_BYPASS_EN
      chk("same_pre_rs1", rs1_data, 32'h00000002);
      chk("same_pre_rs2", rs2_data, 32'h00000002);
`else
      chk("same_pre_rs1", rs1_data, 32'h00000001);
      chk("same_pre_rs2", rs2_data, 32'h00000001);
`endif
      step();
      bubble();
      chk("same_post_rs1", rs1_data, 32'h00000002);
      chk("same_post_rs2", rs2_data, 32'h00000002);
      chk("same_cnt", wb_count, 32'd4);

      // 6a. Reset beats a simultaneous write
      rst = 1'b1;
      drive(2'b10, 5'd4, 32'h0, 32'h00000077);
      step();
      rst = 1'b0;
      bubble();
      rs1_addr = 5'd4;
      rs2_addr = 5'd3;
      #1;
      chk("rstw_x4", rs1_data, 32'h0);
      chk("rstw_x3", rs2_data, 32'h0);
      chk("rstw_cnt", wb_count, 32'd0);

      // Writes resume on the first cycle after reset
      drive(2'b10, 5'd4, 32'h0, 32'h00000044);
      step();
      bubble();
      chk("resume_x4", rs1_data, 32'h00000044);
      chk("resume_cnt", wb_count, 32'd1);

      // 6b. Counter wrap on the 4-bit instance, full count on the 32-bit one
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         drive(2'b10, 5'(1 + (i % 31)), 32'h0, 32'(i + 100));
         step();
         if (i == 14) begin
            chk("wrap_cnt15", 32'(s_wb_count), 32'd15);
         end
      end
      bubble();
      chk("wrap_cnt4", 32'(s_wb_count), 32'd0);
      chk("wrap_cnt32", wb_count, 32'd16);
      rs1_addr = 5'd16;
      #1;
      chk("wrap_x16", rs1_data, 32'd115);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
